alert_dispatch_arbiter: RTL and testbench
=========================================

# alert_dispatch_arbiter

Shares one outbound notification transmitter (the app/email/SMS gateway) among up to eight alert sources, such as the door/window sensor, security alert, air-quality and lock outputs. It works as follows:
- Rising edges on the source alert levels are latched as pending events.
- A round-robin arbiter picks one pending source and hands it to the transmitter over a valid/ready handshake.
- The block waits for completion, retries failed sends and drops the event after a bounded number of attempts.
- A global cooldown is enforced between completed dispatches.

## Interface
Parameters:
- NUM_SRC, 4: number of alert sources, legal range 2..8.
- SRC_W, $clog2(NUM_SRC): width of the source index.
- MAX_RETRY, 3: extra attempts after the first failure, legal range 0..7.
- TIMEOUT, 16: WAIT cycles without tx_done before the attempt counts as failed, legal range 1..255.
- COOLDOWN, 8: idle cycles after a terminal outcome (sent or dropped), legal range 0..255.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alert_in  in  NUM_SRC  per-source alert level.
- notify_valid  out  1  request to the transmitter.
- notify_src  out  SRC_W  source index; stable while notify_valid=1.
- notify_ready  in  1  transmitter accepts the request.
- tx_done  in  1  one-cycle completion pulse from the transmitter.
- tx_err  in  1  qualifies tx_done: 1 means the send failed.
- sent  out  1  one-cycle pulse on successful delivery.
- dropped  out  1  one-cycle pulse when retries are exhausted.
- done_src  out  SRC_W  source for sent/dropped; valid only during the pulse.
- pending  out  NUM_SRC  latched, not-yet-granted events.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
Event capture:
- alert_q is a registered copy of alert_in, reset to 0.
- rise = alert_in & ~alert_q.
- pending[i] is set on rise[i] and cleared when source i is granted (IDLE→REQ).
- If set and clear happen in the same cycle, set wins, so a new event is never lost.
- Repeated edges on a source that is already pending merge into that one pending event.
- A level that is still high when reset is released counts as a rise one cycle after release.

Arbitration:
- Round-robin with pointer rr_ptr, reset to 0.
- The granted source is the first pending index at or above rr_ptr, wrapping modulo NUM_SRC.
- On a grant of source g, rr_ptr becomes (g+1) mod NUM_SRC.

FSM states are IDLE, REQ, WAIT and HOLD:
- IDLE: if pending≠0, grant a source, latch cur_src, clear attempt count, go to REQ.
- REQ: notify_valid=1 and notify_src=cur_src. When notify_valid & notify_ready, clear the timeout counter and go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - tx_done & ~tx_err: sent pulse.
  - tx_done & tx_err, or timeout counter reaching TIMEOUT: attempt fails.
  - Failed with attempt count < MAX_RETRY: attempt count increments and the FSM returns to REQ with the same cur_src.
  - Failed with retries exhausted: dropped pulse.
  - After sent or dropped, go to HOLD; if COOLDOWN=0, go directly to IDLE.
  - If tx_done and timeout coincide, tx_done decides the outcome.
- HOLD: count COOLDOWN cycles, then go to IDLE. Events still latch during HOLD.

Input qualification:
- tx_done is ignored outside WAIT.
- notify_ready is ignored outside REQ.

Counter and output rules:
- The timeout counter is 8 bits and the attempt counter is 3 bits; neither wraps, because each is compared before it increments.
- sent and dropped are mutually exclusive. They pulse in the cycle after the deciding WAIT edge, with done_src=cur_src.

## Timing
Reset:
- While rst_n=0 at an edge, all registers clear.
- Outputs after reset: notify_valid=0, notify_src=0, sent=0, dropped=0, done_src=0, pending=0, busy=0.
- Reset mid-handshake abandons the request; nothing is re-sent.

Latencies (from the edge that samples a 0→1 change on alert_in[i], in an idle block):
- pending[i]=1 after that edge (+1).
- notify_valid=1 after the next edge (+2).
- A handshake completing at edge k enters WAIT at k; a tx_done sampled at edge m produces sent/dropped after edge m.
- On retry, notify_valid reasserts after the failing edge, with no cooldown.
- After a terminal outcome, busy stays high for COOLDOWN further cycles, and the next notify_valid comes no earlier than COOLDOWN+1 cycles after the sent/dropped pulse.
- A timeout fires on the TIMEOUT-th WAIT cycle without tx_done.

## Test plan
- Single event: rise on src 2 with ready tied high and tx_done/tx_err=0 two cycles after the handshake. Required: notify_valid at +2, notify_src=2, sent pulse with done_src=2, busy low 8 cycles after the pulse.
- Simultaneous rises on sources 0,1,3 with rr_ptr=0: grants in order 0,1,3. Then a new rise on 0 and 1 with rr_ptr=0 again: grant 0 first.
- Retry and drop: tx_err=1 on every attempt. Required: exactly 4 handshakes (1+MAX_RETRY), then dropped with done_src correct, no sent pulse.
- Timeout: never assert tx_done. Required: failure declared 16 WAIT cycles after each handshake, giving 4 attempts then dropped. Repeat with tx_done on cycle 16 and require tx_done to win.
- Event during in-flight: source 1 rises again while its own dispatch is in WAIT. Required: pending[1]=1 after the grant clear, and a second dispatch of source 1 after cooldown. A rise in the same cycle as the grant clear must leave pending set.
- Reset mid-REQ: drive rst_n low while notify_valid=1 and ready=0. Required: all outputs 0 after the edge. With an alert held high through reset, a rise is registered one cycle after release.

Source files
------------

// File: rtl/alert_dispatch_arbiter.sv
// Shares one notification transmitter among NUM_SRC alert sources: edge capture,
// round-robin grant, valid/ready request, completion wait with retry/drop, cooldown.
//
// state | meaning
// IDLE  | no dispatch in flight; grants the next pending source
// REQ   | notify_valid high for cur_src, waiting for notify_ready
// WAIT  | request accepted, waiting for tx_done or timeout
// HOLD  | cooldown after a sent/dropped outcome
module alert_dispatch_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_W     = $clog2(NUM_SRC),
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 16,
  parameter int COOLDOWN  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] alert_in,
  output logic               notify_valid,
  output logic [SRC_W-1:0]   notify_src,
  input  logic               notify_ready,
  input  logic               tx_done,
  input  logic               tx_err,
  output logic               sent,
  output logic               dropped,
  output logic [SRC_W-1:0]   done_src,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [7:0]       TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0]       CD_LAST   = 8'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [SRC_W-1:0] SRC_LAST  = SRC_W'(NUM_SRC - 1);
  // With no cooldown a terminal outcome returns straight to IDLE.
  localparam state_t           POST_TERM = (COOLDOWN == 0) ? IDLE : HOLD;

  state_t             state;
  logic [NUM_SRC-1:0] alert_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] grant_clr;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   cur_src;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_now;
  logic [7:0]         tout_cnt;
  logic [7:0]         cd_cnt;
  logic [2:0]         attempt;
  logic               timeout_hit;

  assign rise        = alert_in & ~alert_q;
  assign grant_now   = (state == IDLE) && (|pending);
  assign timeout_hit = (tout_cnt == TO_LAST);
  assign notify_src  = cur_src;
  assign busy        = (state != IDLE);

  // Scan downward so the last hit written is the first pending index at/after rr_ptr.
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (pending[SRC_W'((int'(rr_ptr) + k) % NUM_SRC)]) begin
        grant_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (grant_now) begin
      grant_clr[grant_idx] = 1'b1;
    end
  end

  // Rise is ORed after the grant clear so a same-cycle new event survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alert_q <= '0;
      pending <= '0;
      rr_ptr  <= '0;
    end else begin
      alert_q <= alert_in;
      pending <= (pending & ~grant_clr) | rise;
      if (grant_now) begin
        rr_ptr <= (grant_idx == SRC_LAST) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_src      <= '0;
      attempt      <= '0;
      tout_cnt     <= '0;
      cd_cnt       <= '0;
      notify_valid <= 1'b0;
      sent         <= 1'b0;
      dropped      <= 1'b0;
      done_src     <= '0;
    end else begin
      sent    <= 1'b0;
      dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_now) begin
            cur_src      <= grant_idx;
            attempt      <= '0;
            notify_valid <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (notify_ready) begin
            tout_cnt     <= '0;
            notify_valid <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // tx_done is checked first so it overrides a coincident timeout.
          if (tx_done && !tx_err) begin
            sent     <= 1'b1;
            done_src <= cur_src;
            cd_cnt   <= '0;
            state    <= POST_TERM;
          end else if (tx_done || timeout_hit) begin
            if (attempt < RETRY_MAX) begin
              attempt      <= attempt + 3'd1;
              notify_valid <= 1'b1;
              state        <= REQ;
            end else begin
              dropped  <= 1'b1;
              done_src <= cur_src;
              cd_cnt   <= '0;
              state    <= POST_TERM;
            end
          end else begin
            tout_cnt <= tout_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cd_cnt == CD_LAST) begin
            state <= IDLE;
          end else begin
            cd_cnt <= cd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alert_dispatch_arbiter.sv
// Bench for alert_dispatch_arbiter: arbitration table, directed corner sequences,
// and randomized traffic checked every cycle against a timestamp-based reference model.
module tb_alert_dispatch_arbiter;
  localparam int N = 4;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT = 16;
  localparam int COOLDOWN = 8;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_HOLD = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] alert_in = '0;
  logic         notify_valid;
  logic [1:0]   notify_src;
  logic         notify_ready = 1'b0;
  logic         tx_done = 1'b0;
  logic         tx_err = 1'b0;
  logic         sent;
  logic         dropped;
  logic [1:0]   done_src;
  logic [N-1:0] pending;
  logic         busy;

  alert_dispatch_arbiter #(
    .NUM_SRC(N), .SRC_W(2), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alert_in(alert_in),
    .notify_valid(notify_valid), .notify_src(notify_src), .notify_ready(notify_ready),
    .tx_done(tx_done), .tx_err(tx_err), .sent(sent), .dropped(dropped),
    .done_src(done_src), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tcyc = 0;

  // reference model: dispatch phase plus absolute-time deadlines
  int         m_phase = PH_IDLE;
  int         m_cur = 0, m_rr = 0, m_tries = 0, m_t0 = 0, m_t_end = 0, m_done_src = 0;
  logic [N-1:0] m_pend = '0, m_prev = '0;
  logic       m_sent = 1'b0, m_drop = 1'b0;

  // transmitter responder
  int   rdy_mode = 1;     // 0 low, 1 high, 2 random
  int   done_dly = 1;     // 0 never
  int   err_mode = 0;     // 0 ok, 1 error, 2 random
  bit   rand_done = 0, spurious = 0;
  bit   armed = 0;
  int   since = 0, cur_dly = 0;
  bit   v_prev = 0;
  int   hs_cnt = 0, sent_cnt = 0, drop_cnt = 0;
  int   grant_q[$];

  typedef struct packed {
    logic [3:0]      mask;
    logic [2:0]      n;
    logic [3:0][1:0] ord;
  } rec_t;
  rec_t tbl[7];

  function automatic rec_t mk(logic [3:0] mask, int n, int a, int b, int c, int d);
    rec_t r;
    r.mask = mask;
    r.n = 3'(n);
    r.ord[0] = 2'(a);
    r.ord[1] = 2'(b);
    r.ord[2] = 2'(c);
    r.ord[3] = 2'(d);
    return r;
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, exp, tcyc);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] rise;
    bit fail, fin;
    m_sent = 1'b0;
    m_drop = 1'b0;
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_rr = 0; m_cur = 0; m_tries = 0;
      m_phase = PH_IDLE; m_done_src = 0;
      return;
    end
    rise = alert_in & ~m_prev;
    m_prev = alert_in;
    case (m_phase)
      PH_IDLE: if (m_pend != 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_pend[(m_rr + k) % N]) begin
            m_cur = (m_rr + k) % N;
            break;
          end
        end
        m_pend[m_cur] = 1'b0;
        m_rr = (m_cur + 1) % N;
        m_tries = 0;
        m_phase = PH_REQ;
      end
      PH_REQ: if (notify_ready) begin
        m_phase = PH_WAIT;
        m_t0 = tcyc;
      end
      PH_WAIT: begin
        fail = 0;
        fin = 0;
        if (tx_done) begin
          if (tx_err) fail = 1;
          else begin m_sent = 1'b1; fin = 1; end
        end else if (tcyc - m_t0 == TIMEOUT) fail = 1;
        if (fail) begin
          if (m_tries < MAX_RETRY) begin m_tries++; m_phase = PH_REQ; end
          else begin m_drop = 1'b1; fin = 1; end
        end
        if (fin) begin
          m_done_src = m_cur;
          m_t_end = tcyc + COOLDOWN;
          m_phase = (COOLDOWN == 0) ? PH_IDLE : PH_HOLD;
        end
      end
      default: if (tcyc == m_t_end) m_phase = PH_IDLE;
    endcase
    m_pend = m_pend | rise;
  endtask

  // One clock: advance model with the inputs the edge sampled, compare, then redrive.
  task automatic tick();
    bit hs_now;
    @(negedge clk);
    tcyc++;
    model_step();
    hs_now = rst_n && v_prev && notify_ready;
    if (hs_now) begin
      hs_cnt++;
      armed = 1;
      since = 0;
      cur_dly = rand_done ? int'($urandom_range(1, 20)) : done_dly;
    end else if (armed) since++;
    if (!rst_n) armed = 0;

    chk("valid", int'(notify_valid), int'(m_phase == PH_REQ));
    chk("busy", int'(busy), int'(m_phase != PH_IDLE));
    chk("pending", int'(pending), int'(m_pend));
    chk("sent", int'(sent), int'(m_sent));
    chk("dropped", int'(dropped), int'(m_drop));
    if (m_phase == PH_REQ) chk("notify_src", int'(notify_src), m_cur);
    if (m_sent || m_drop) chk("done_src", int'(done_src), m_done_src);

    if (sent) sent_cnt++;
    if (dropped) drop_cnt++;
    if (notify_valid && !v_prev) grant_q.push_back(int'(notify_src));
    v_prev = notify_valid;

    case (rdy_mode)
      0: notify_ready = 1'b0;
      1: notify_ready = 1'b1;
      default: notify_ready = 1'($urandom_range(0, 1));
    endcase
    tx_done = 1'b0;
    tx_err = 1'b0;
    if (armed && cur_dly != 0 && since == cur_dly - 1) begin
      tx_done = 1'b1;
      tx_err = (err_mode == 2) ? 1'($urandom_range(0, 1)) : (err_mode == 1);
      armed = 0;
    end else if (spurious && $urandom_range(0, 31) == 0) begin
      tx_done = 1'b1;
      tx_err = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain(string nm, int lim);
    int g;
    for (g = 0; g < lim; g++) begin
      tick();
      if (!busy && pending == '0) break;
    end
    chk(nm, int'(g < lim), 1);
  endtask

  initial begin
    int g, te, m;
    tbl[0] = mk(4'b1011, 3, 0, 1, 3, 0);
    tbl[1] = mk(4'b0011, 2, 0, 1, 0, 0);
    tbl[2] = mk(4'b0101, 2, 2, 0, 0, 0);
    tbl[3] = mk(4'b1111, 4, 1, 2, 3, 0);
    tbl[4] = mk(4'b1000, 1, 3, 0, 0, 0);
    tbl[5] = mk(4'b0100, 1, 2, 0, 0, 0);
    tbl[6] = mk(4'b0011, 2, 0, 1, 0, 0);

    repeat (3) tick();
    chk("rst_valid", int'(notify_valid), 0);
    chk("rst_src", int'(notify_src), 0);
    chk("rst_sent", int'(sent), 0);
    chk("rst_dropped", int'(dropped), 0);
    chk("rst_done_src", int'(done_src), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // round-robin table, all sends succeed
    rdy_mode = 1; done_dly = 1; err_mode = 0;
    for (int r = 0; r < 7; r++) begin
      grant_q.delete();
      alert_in = tbl[r].mask;
      tick();
      alert_in = '0;
      drain($sformatf("tbl%0d_drain", r), 400);
      chk($sformatf("tbl%0d_count", r), grant_q.size(), int'(tbl[r].n));
      for (int j = 0; j < int'(tbl[r].n); j++)
        if (j < grant_q.size()) chk($sformatf("tbl%0d_grant%0d", r, j), grant_q[j], int'(tbl[r].ord[j]));
    end

    // single event on source 2
    done_dly = 2;
    te = tcyc + 1;
    alert_in = 4'b0100;
    tick();
    chk("a_pend", int'(pending[2]), 1);
    chk("a_valid_early", int'(notify_valid), 0);
    tick();
    chk("a_valid", int'(notify_valid), 1);
    chk("a_src", int'(notify_src), 2);
    alert_in = '0;
    for (g = 0; g < 20 && !sent; g++) tick();
    chk("a_sent", int'(sent), 1);
    chk("a_sent_lat", tcyc - te, 4);
    chk("a_done_src", int'(done_src), 2);
    repeat (7) tick();
    chk("a_busy_hold", int'(busy), 1);
    tick();
    chk("a_busy_low", int'(busy), 0);
    drain("a_drain", 50);

    // every attempt errors: 1+MAX_RETRY handshakes then drop
    err_mode = 1; hs_cnt = 0; sent_cnt = 0; drop_cnt = 0;
    te = tcyc + 1;
    alert_in = 4'b1000;
    tick();
    alert_in = '0;
    for (g = 0; g < 200 && !dropped; g++) tick();
    chk("c_dropped", int'(dropped), 1);
    chk("c_drop_lat", tcyc - te, 13);
    chk("c_done_src", int'(done_src), 3);
    chk("c_handshakes", hs_cnt, 4);
    drain("c_drain", 50);
    chk("c_sent_cnt", sent_cnt, 0);
    chk("c_drop_cnt", drop_cnt, 1);

    // no tx_done at all: four 16-cycle timeouts
    err_mode = 0; done_dly = 0; hs_cnt = 0; sent_cnt = 0;
    te = tcyc + 1;
    alert_in = 4'b0010;
    tick();
    alert_in = '0;
    for (g = 0; g < 300 && !dropped; g++) tick();
    chk("d_dropped", int'(dropped), 1);
    chk("d_drop_lat", tcyc - te, 69);
    chk("d_done_src", int'(done_src), 1);
    chk("d_handshakes", hs_cnt, 4);
    drain("d_drain", 50);
    chk("d_sent_cnt", sent_cnt, 0);

    // tx_done on the 16th WAIT cycle beats the timeout
    done_dly = 16; hs_cnt = 0; drop_cnt = 0;
    te = tcyc + 1;
    alert_in = 4'b0001;
    tick();
    alert_in = '0;
    for (g = 0; g < 100 && !sent && !dropped; g++) tick();
    chk("d16_sent", int'(sent), 1);
    chk("d16_lat", tcyc - te, 18);
    chk("d16_handshakes", hs_cnt, 1);
    drain("d16_drain", 50);
    chk("d16_drop_cnt", drop_cnt, 0);

    // new event while in flight, and a rise coinciding with the grant clear
    done_dly = 4;
    grant_q.delete();
    te = tcyc + 1;
    alert_in = 4'b0010;
    tick();
    alert_in = '0;
    tick();
    tick();
    alert_in = 4'b0010;
    tick();
    chk("e_pend_inflight", int'(pending[1]), 1);
    for (g = 0; g < 20 && !sent; g++) tick();
    chk("e_sent", int'(sent), 1);
    m = tcyc;
    chk("e_sent_lat", m - te, 6);
    alert_in = 4'b1010;
    tick();
    alert_in = 4'b0010;
    while (tcyc < m + 8) tick();
    chk("e_idle_after_cd", int'(busy), 0);
    alert_in = 4'b1010;
    tick();
    chk("e_grant_valid", int'(notify_valid), 1);
    chk("e_grant_src", int'(notify_src), 3);
    chk("e_pend_kept", int'(pending[3]), 1);
    alert_in = '0;
    drain("e_drain", 200);
    chk("e_grants", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      chk("e_g0", grant_q[0], 1);
      chk("e_g1", grant_q[1], 3);
      chk("e_g2", grant_q[2], 1);
      chk("e_g3", grant_q[3], 3);
    end

    // reset while requesting, alert level held through reset
    rdy_mode = 0;
    alert_in = 4'b0001;
    for (g = 0; g < 10 && !notify_valid; g++) tick();
    chk("f_valid", int'(notify_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("f_valid0", int'(notify_valid), 0);
    chk("f_src0", int'(notify_src), 0);
    chk("f_sent0", int'(sent), 0);
    chk("f_dropped0", int'(dropped), 0);
    chk("f_done_src0", int'(done_src), 0);
    chk("f_pending0", int'(pending), 0);
    chk("f_busy0", int'(busy), 0);
    rst_n = 1'b1;
    tick();
    chk("f_rise_after_rel", int'(pending[0]), 1);
    chk("f_valid_rel", int'(notify_valid), 0);
    tick();
    chk("f_revalid", int'(notify_valid), 1);
    rdy_mode = 1;
    alert_in = '0;
    drain("f_drain", 100);

    // randomized traffic against the model
    rdy_mode = 2; err_mode = 2; rand_done = 1; spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) alert_in[b] = ~alert_in[b];
      if (i == 2000) rst_n = 1'b0;
      if (i == 2002) rst_n = 1'b1;
      tick();
    end
    alert_in = '0;
    rdy_mode = 1;
    spurious = 0;
    drain("rand_drain", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
